// File: rtl/hdmi_period_scheduler_if.sv
// Island packet handshake between the packet source and the period scheduler.
//   island_req  source -> sched  level: a packet set is ready
//   isl_valid   source -> sched  head symbols valid (first-word-fall-through)
//   isl_ch0..2  source -> sched  TERC4-encoded island symbols
//   island_ack  sched -> source  1-cycle pulse: island launched
//   island_rd   sched -> source  pop the head symbols this cycle
interface hdmi_period_scheduler_if;
  logic       island_req;
  logic       isl_valid;
  logic [9:0] isl_ch0;
  logic [9:0] isl_ch1;
  logic [9:0] isl_ch2;
  logic       island_ack;
  logic       island_rd;

  modport master (
    output island_req, isl_valid, isl_ch0, isl_ch1, isl_ch2,
    input  island_ack, island_rd
  );

  modport slave (
    input  island_req, isl_valid, isl_ch0, isl_ch1, isl_ch2,
    output island_ack, island_rd
  );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: picks the 10-bit symbol per TMDS channel every pixel
// clock (control, preambles, guard bands, video, data-island packets).
// Video/syncs run through a 10-deep delay line so that 8 preamble + 2 guard
// cycles can be inserted ahead of active video; symbol outputs are registered,
// giving 11 cycles of video latency.
// Ports:
//   i_pixclk, i_reset_n         pixel clock, async active-low reset
//   i_de, i_hsync, i_vsync      raw timing from the timing generator
//   i_vid_ch0..2                TMDS video symbols aligned with i_de
//   i_clr_err                   clears the sticky flags
//   isl (slave)                 island source handshake and symbols
//   o_ch0..2_sym                symbols to serializer (blue/green/red)
//   o_sync_d                    {vsync,hsync} delayed 10 cycles
//   o_underrun, o_sched_err     sticky error flags
module hdmi_period_scheduler #(
  parameter int PKTS          = 1,
  parameter int ISLAND_OFFSET = 16
) (
  input  logic                    i_pixclk,
  input  logic                    i_reset_n,
  input  logic                    i_de,
  input  logic                    i_hsync,
  input  logic                    i_vsync,
  input  logic [9:0]              i_vid_ch0,
  input  logic [9:0]              i_vid_ch1,
  input  logic [9:0]              i_vid_ch2,
  input  logic                    i_clr_err,
  hdmi_period_scheduler_if.slave  isl,
  output logic [9:0]              o_ch0_sym,
  output logic [9:0]              o_ch1_sym,
  output logic [9:0]              o_ch2_sym,
  output logic [1:0]              o_sync_d,
  output logic                    o_underrun,
  output logic                    o_sched_err
);

  localparam int DLY      = 10;
  localparam int DATA_LEN = 32 * PKTS;
  localparam int CW       = 10;
  localparam int CCW      = 16;

  localparam logic [CW-1:0]  DATA_LAST = CW'(DATA_LEN - 1);
  localparam logic [CW-1:0]  PRE_LAST  = CW'(7);
  localparam logic [CW-1:0]  GB_LAST   = CW'(1);
  // The launch cycle itself counts as a control cycle, so ISLAND_OFFSET
  // control symbols go out before the first preamble symbol.
  localparam logic [CCW-1:0] LAUNCH_AT = CCW'(ISLAND_OFFSET - 1);

  localparam logic [9:0] CTL_00  = 10'b1101010100;
  localparam logic [9:0] CTL_01  = 10'b0010101011;
  localparam logic [9:0] GB_V02  = 10'b1011001100;
  localparam logic [9:0] GB_V1   = 10'b0100110011;
  localparam logic [9:0] GB_ISL  = 10'b0100110011;
  localparam logic [9:0] TERC4_0 = 10'b1010011100;

  typedef enum logic [2:0] {CTL, VPRE, VGB, VIDEO, DPRE, DLGB, DATA, DTGB} state_e;

  typedef struct packed {
    logic            de;
    logic            vs;
    logic            hs;
    logic [2:0][9:0] vid;
  } px_t;

  function automatic logic [9:0] ctl_sym(input logic [1:0] idx);
    case (idx)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4(input logic [3:0] d);
    case (d)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  // ---------------- delay line ----------------
  px_t            px_in;
  px_t            px_d;
  px_t [DLY-1:0]  dl_q;
  logic [1:0]     sync_d;

  assign px_in  = {i_de, i_vsync, i_hsync, i_vid_ch2, i_vid_ch1, i_vid_ch0};
  assign px_d   = dl_q[DLY-1];
  assign sync_d = {px_d.vs, px_d.hs};

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) dl_q <= '0;
    else            dl_q <= {dl_q[DLY-2:0], px_in};
  end

  // ---------------- scheduler ----------------
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CCW-1:0]  ctl_cnt_q, ctl_cnt_d;
  logic [2:0][9:0] sym_q, sym_d;
  logic            ack_q, ack_d;
  logic            rd_q, rd_d;
  logic            underrun_q, err_q;
  logic            de_prev_q;
  logic            de_rise;
  logic            err_set;
  logic [CW-1:0]   isl_last;

  assign de_rise  = i_de & ~de_prev_q;
  assign isl_last = (state_q == DATA) ? DATA_LAST :
                    (state_q == DPRE) ? PRE_LAST  : GB_LAST;

  // state_q is the period whose symbols are on the outputs this cycle;
  // state_d is decided from this cycle's inputs and drives next cycle's symbols.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    ctl_cnt_d = ctl_cnt_q;
    ack_d     = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      CTL: begin
        cnt_d = '0;
        if (ctl_cnt_q != '1) ctl_cnt_d = ctl_cnt_q + CCW'(1);
        if (px_d.de) begin
          // video reached the delay-line tap without a preamble (short blanking)
          state_d = VIDEO;
          err_set = de_rise;
        end else if (de_rise) begin
          state_d = VPRE;
        end else if (isl.island_req && ctl_cnt_q >= LAUNCH_AT) begin
          state_d = DPRE;
          ack_d   = 1'b1;
        end
      end
      VPRE: begin
        err_set = de_rise;
        if (cnt_q == PRE_LAST) begin
          state_d = VGB;
          cnt_d   = '0;
        end
      end
      VGB: begin
        err_set = de_rise;
        if (cnt_q == GB_LAST) begin
          state_d = VIDEO;
          cnt_d   = '0;
        end
      end
      VIDEO: begin
        cnt_d = '0;
        if (!px_d.de) begin
          // a rise exactly 10 cycles after the fall still fits a full preamble
          if (de_rise) begin
            state_d = VPRE;
          end else begin
            state_d   = CTL;
            ctl_cnt_d = '0;
          end
        end else begin
          err_set = de_rise;
        end
      end
      DPRE, DLGB, DATA, DTGB: begin
        if (de_rise) begin
          state_d = VPRE;
          cnt_d   = '0;
          err_set = 1'b1;
        end else if (cnt_q == isl_last) begin
          cnt_d = '0;
          case (state_q)
            DPRE:    state_d = DLGB;
            DLGB:    state_d = DATA;
            DATA:    state_d = DTGB;
            default: begin
              state_d   = CTL;
              ctl_cnt_d = '0;
            end
          endcase
        end
      end
      default: state_d = CTL;
    endcase
    // Pop one cycle ahead: the head captured while rd is high is what goes
    // out on the following DATA cycle.
    rd_d = (state_d == DLGB && cnt_d == GB_LAST) ||
           (state_d == DATA && cnt_d != DATA_LAST);
  end

  always_comb begin
    sym_d[0] = ctl_sym(sync_d);
    sym_d[1] = CTL_00;
    sym_d[2] = CTL_00;
    case (state_d)
      VPRE: sym_d[1] = CTL_01;
      VGB: begin
        sym_d[0] = GB_V02;
        sym_d[1] = GB_V1;
        sym_d[2] = GB_V02;
      end
      VIDEO: sym_d = px_d.vid;
      DPRE: begin
        sym_d[1] = CTL_01;
        sym_d[2] = CTL_01;
      end
      DLGB, DTGB: begin
        sym_d[0] = terc4({2'b11, sync_d});
        sym_d[1] = GB_ISL;
        sym_d[2] = GB_ISL;
      end
      DATA: begin
        if (isl.isl_valid) begin
          sym_d = {isl.isl_ch2, isl.isl_ch1, isl.isl_ch0};
        end else begin
          sym_d[0] = terc4({2'b00, sync_d});
          sym_d[1] = TERC4_0;
          sym_d[2] = TERC4_0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= CTL;
      cnt_q      <= '0;
      ctl_cnt_q  <= '0;
      sym_q      <= {3{CTL_00}};
      ack_q      <= 1'b0;
      rd_q       <= 1'b0;
      underrun_q <= 1'b0;
      err_q      <= 1'b0;
      de_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctl_cnt_q  <= ctl_cnt_d;
      sym_q      <= sym_d;
      ack_q      <= ack_d;
      rd_q       <= rd_d;
      de_prev_q  <= i_de;
      // a set in the same cycle as a clear wins
      underrun_q <= (underrun_q & ~i_clr_err) | (rd_q & ~isl.isl_valid);
      err_q      <= (err_q & ~i_clr_err) | err_set;
    end
  end

  assign o_ch0_sym      = sym_q[0];
  assign o_ch1_sym      = sym_q[1];
  assign o_ch2_sym      = sym_q[2];
  assign o_sync_d       = sync_d;
  assign o_underrun     = underrun_q;
  assign o_sched_err    = err_q;
  assign isl.island_ack = ack_q;
  assign isl.island_rd  = rd_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler: reset, control sync coding, video
// preamble/guard/latency, island launch timing, underrun substitution, abort
// on de rise, sticky flag clear and mid-island reset.
module tb_hdmi_period_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0, hs = 1'b0, vs = 1'b0, clr = 1'b0;
  logic [9:0] v0 = '0, v1 = '0, v2 = '0;
  logic [9:0] ch0, ch1, ch2;
  logic [1:0] sync_d;
  logic       underrun, serr;

  hdmi_period_scheduler_if isl();

  hdmi_period_scheduler #(.PKTS(1), .ISLAND_OFFSET(16)) dut (
    .i_pixclk   (clk),
    .i_reset_n  (rst_n),
    .i_de       (de),
    .i_hsync    (hs),
    .i_vsync    (vs),
    .i_vid_ch0  (v0),
    .i_vid_ch1  (v1),
    .i_vid_ch2  (v2),
    .i_clr_err  (clr),
    .isl        (isl),
    .o_ch0_sym  (ch0),
    .o_ch1_sym  (ch1),
    .o_ch2_sym  (ch2),
    .o_sync_d   (sync_d),
    .o_underrun (underrun),
    .o_sched_err(serr)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C00  = 10'b1101010100;
  localparam logic [9:0] C01  = 10'b0010101011;
  localparam logic [9:0] GBV0 = 10'b1011001100;
  localparam logic [9:0] GBV1 = 10'b0100110011;
  localparam logic [9:0] GBI  = 10'b0100110011;
  localparam logic [9:0] TD   = 10'b1001110001;  // TERC4(4'b1101)
  localparam logic [9:0] T0   = 10'b1010011100;  // TERC4(0)
  localparam logic [9:0] T1   = 10'b1001100011;  // TERC4(1)

  int n_chk = 0;
  int n_err = 0;
  int idx = 0;
  int rd_cnt = 0;
  logic req_en = 1'b0;

  function automatic logic [9:0] vid0(input int k); return 10'(k * 3 + 1);   endfunction
  function automatic logic [9:0] vid1(input int k); return 10'(k * 5 + 2);   endfunction
  function automatic logic [9:0] vid2(input int k); return 10'(k + 400);     endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    isl.island_req = 1'b0;
    isl.isl_valid  = 1'b1;
    isl.isl_ch0    = '0;
    isl.isl_ch1    = '0;
    isl.isl_ch2    = '0;

    repeat (3) tick();
    chk("rst_ch0", ch0, C00);
    chk("rst_ch1", ch1, C00);
    chk("rst_ch2", ch2, C00);
    chk("rst_ack", isl.island_ack, 0);
    chk("rst_rd", isl.island_rd, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_serr", serr, 0);
    chk("rst_sync", sync_d, 0);

    hs = 1'b1;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("sync_d_10", sync_d, 2'b01);
    chk("ch0_at10", ch0, C00);
    tick();
    chk("ch0_at11", ch0, C01);
    chk("ch1_at11", ch1, C00);
    chk("ch2_at11", ch2, C00);

    for (int k = 0; k < 186; k++) begin
      tick();
      de = (k >= 20 && k < 40) || (k >= 140 && k < 145);
      v0 = vid0(k);
      v1 = vid1(k);
      v2 = vid2(k);
      if (k == 40 || k == 112 || k == 156) req_en = 1'b1;
      isl.island_req = req_en;
      isl.isl_valid  = (k != 81);
      isl.isl_ch0    = 10'(500 + idx);
      isl.isl_ch1    = 10'(600 + idx);
      isl.isl_ch2    = 10'(700 + idx);
      clr = (k == 112);
      case (k)
        21: begin
          chk("vpre0_ch0", ch0, C01);
          chk("vpre0_ch1", ch1, C01);
          chk("vpre0_ch2", ch2, C00);
        end
        28: chk("vpre7_ch1", ch1, C01);
        29: begin
          chk("vgb_ch0", ch0, GBV0);
          chk("vgb_ch1", ch1, GBV1);
          chk("vgb_ch2", ch2, GBV0);
        end
        30: chk("vgb1_ch1", ch1, GBV1);
        31: begin
          chk("vid_first_ch0", ch0, vid0(20));
          chk("vid_first_ch1", ch1, vid1(20));
          chk("vid_first_ch2", ch2, vid2(20));
        end
        50: chk("vid_last_ch0", ch0, vid0(39));
        51: begin
          chk("ctl_after_vid_ch1", ch1, C00);
          chk("ctl_after_vid_ch0", ch0, C01);
        end
        66: chk("ack_early", isl.island_ack, 0);
        67: begin
          chk("ack", isl.island_ack, 1);
          chk("dpre_ch1", ch1, C01);
          chk("dpre_ch2", ch2, C01);
        end
        68: chk("ack_pulse", isl.island_ack, 0);
        74: chk("dpre7_ch2", ch2, C01);
        75: begin
          chk("dlgb_ch0", ch0, TD);
          chk("dlgb_ch1", ch1, GBI);
          chk("rd_pre", isl.island_rd, 0);
        end
        76: begin
          chk("rd_first", isl.island_rd, 1);
          chk("dlgb1_ch0", ch0, TD);
        end
        77: begin
          chk("data0_ch0", ch0, 10'd500);
          chk("data0_ch2", ch2, 10'd700);
        end
        81: begin
          chk("underrun_pre", underrun, 0);
          chk("data4_ch1", ch1, 10'd604);
        end
        82: begin
          chk("subst_ch0", ch0, T1);
          chk("subst_ch1", ch1, T0);
          chk("subst_ch2", ch2, T0);
          chk("underrun_set", underrun, 1);
        end
        83: chk("data6_ch0", ch0, 10'd505);
        108: begin
          chk("data31_ch0", ch0, 10'd530);
          chk("rd_done", isl.island_rd, 0);
        end
        109: begin
          chk("dtgb_ch0", ch0, TD);
          chk("dtgb_ch2", ch2, GBI);
        end
        111: begin
          chk("ctl_after_isl_ch1", ch1, C00);
          chk("ctl_after_isl_ch0", ch0, C01);
          chk("rd_count", rd_cnt, 32);
          chk("serr_clean", serr, 0);
        end
        112: chk("underrun_sticky", underrun, 1);
        113: chk("underrun_clr", underrun, 0);
        127: chk("ack2", isl.island_ack, 1);
        137: chk("data0b_ch0", ch0, 10'd531);
        141: begin
          chk("abort_ch1", ch1, C01);
          chk("abort_ch2", ch2, C00);
          chk("abort_rd", isl.island_rd, 0);
          chk("abort_serr", serr, 1);
        end
        151: chk("abort_vid_ch0", ch0, vid0(140));
        155: chk("abort_vid_last", ch0, vid0(144));
        156: chk("ctl_after_abort", ch1, C00);
        172: chk("ack3", isl.island_ack, 1);
        181: chk("rd3", isl.island_rd, 1);
        184: begin
          chk("serr_sticky", serr, 1);
          chk("rd3_data", isl.island_rd, 1);
        end
        default: ;
      endcase
      if (isl.island_ack) req_en = 1'b0;
      if (isl.island_rd) begin
        if (k <= 111) rd_cnt++;
        if (isl.isl_valid) idx++;
      end
    end

    // reset asserted in the middle of the third island's DATA period
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_ch0", ch0, C00);
    chk("mrst_ch1", ch1, C00);
    chk("mrst_ch2", ch2, C00);
    chk("mrst_rd", isl.island_rd, 0);
    chk("mrst_ack", isl.island_ack, 0);
    chk("mrst_serr", serr, 0);
    chk("mrst_sync", sync_d, 0);
    de = 1'b0;
    isl.island_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("flush_ch0", ch0, C00);
    chk("flush_ch1", ch1, C00);
    chk("flush_rd", isl.island_rd, 0);
    repeat (9) tick();
    chk("recover_ch0", ch0, C01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
